ctrl_burst_decoder: RTL
=======================

# ctrl_burst_decoder

Registered, handshaked successor to the combinational main decoder. Decodes each instruction's type/op/immediate fields into datapath control signals and registers them in one output stage with valid/ready flow control. Adds parametrised colour-channel count and a vector mode in which one load/store expands into a multi-beat burst over all channels. Sits between instruction fetch and the register-file/ALU/memory datapath.

## Interface
- CHANNELS, 3, number of memory colour channels, legal range 1..(2^CH_W − 1)
- CH_W, 2, width of the channel index; channel 0 means "no channel"
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  instruction fields valid
- in_ready  out  1  block accepts instruction this cycle
- tipo  in  2  instruction class
- op  in  2  operation within class
- Inm  in  1  immediate-select bit
- vec  in  1  vector request: memory op bursts over all channels
- flush  in  1  synchronous pipeline flush
- out_valid  out  1  control beat valid
- out_ready  in  1  downstream accepts beat
- RegWrite, ALUSrc, MemWrite, ResultSrc, Branch, Jump, PCDirection  out  1 each  datapath controls
- ImmSrc  out  2  immediate source
- ALUOp  out  2  ALU control
- Channel  out  CH_W  memory channel index
- last  out  1  final beat of instruction
- err  out  1  illegal-channel flag, valid with beat

## Operation
- Decode (defaults all 0):
  - tipo 00: RegWrite=1, ALUSrc=Inm, ALUOp=10.
  - tipo 01: ALUSrc=Inm, RegWrite=1; op 00 MOV (ResultSrc=0); op≠00 load (ResultSrc=1, Channel=op).
  - tipo 10: op 00 jump (Jump=1, ImmSrc=10, PCDirection=Inm); op 01 branch-link (Jump=1, ImmSrc=10, RegWrite=1); op 10 CMP (ALUOp=01); op 11 BEQ (Branch=1).
  - tipo 11: ALUSrc=Inm; op 00 RET (Jump=1, ImmSrc=10); op≠00 store (MemWrite=1, Channel=op).
- Memory op = load or store (Channel field ≠ 0 above).
- Non-vector memory op with op > CHANNELS: RegWrite=0, MemWrite=0, Channel=0, err=1; other fields as decoded.
- vec ignored for non-memory ops (single beat, last=1).
- Vector memory op: CHANNELS beats, Channel=1,2,…,CHANNELS, all other controls identical, err=0, last=1 only on beat CHANNELS.
- FSM: IDLE (output empty) → HOLD on accept of single-beat instr, → BURST on accept of vector memory op. HOLD: out_ready with new accept stays HOLD/goes BURST; out_ready without accept → IDLE. BURST: beat counter advances on out_ready; final beat accepted → same rules as HOLD.
- in_ready = !rst && !flush && (IDLE || (HOLD && out_ready) || (BURST && last && out_ready)).
- All control outputs, Channel, last, err are 0 whenever out_valid=0.
- flush: next cycle out_valid=0, FSM=IDLE, counter cleared; in_valid ignored in flush cycle; flush with out_ready same cycle: beat counts as consumed, nothing new registered.

## Timing
- Reset: out_valid=0, all controls/Channel/last/err=0, FSM=IDLE, counter=0; in_ready=0 during rst, 1 the cycle after release.
- Latency: instruction accepted at edge N → beat valid after edge N (visible cycle N+1).
- Throughput: 1 instruction/cycle single-beat with out_ready held 1; vector op occupies CHANNELS cycles, next accept in cycle of final beat.
- out_ready=0: current beat and all outputs held stable; no accept.
- Counter wraps to 1 only via new vector accept; never exceeds CHANNELS.
- rst mid-burst: burst aborted, state as reset next cycle.

## Test plan
- Reset then tipo=00 Inm=1, out_ready=1 → next cycle out_valid=1, RegWrite=1, ALUSrc=1, ALUOp=10, last=1; back-to-back instructions each cycle, in_ready stays 1.
- tipo=01 op=10 vec=1, CHANNELS=3 → 3 beats Channel=1,2,3, RegWrite=1, ResultSrc=1, last only on beat 3, in_ready=0 for first two beats.
- Vector store with out_ready toggling 1,0,1,0,1 → beats held during 0 cycles, Channel order 1,2,3, no dropped/duplicated beats.
- CHANNELS=2, tipo=11 op=11 vec=0 → MemWrite=0, Channel=0, err=1, out_valid=1.
- flush asserted during beat 2 of 3 with in_valid=1 → next cycle out_valid=0, in_ready=1, no accept in flush cycle.
- rst pulsed mid-burst → all outputs 0 next cycle; tipo=10 op=00 Inm=1 after release → Jump=1, ImmSrc=10, PCDirection=1.

Source files
------------

// File: rtl/ctrl_burst_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_burst_decoder
// Brief    : Registered instruction-to-control decoder with valid/ready flow
//            control and vector load/store bursts over all colour channels.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_burst_decoder #(
    parameter int CHANNELS = 3,
    parameter int CH_W     = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      tipo,
    input  logic [1:0]      op,
    input  logic            Inm,
    input  logic            vec,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            RegWrite,
    output logic            ALUSrc,
    output logic            MemWrite,
    output logic            ResultSrc,
    output logic            Branch,
    output logic            Jump,
    output logic            PCDirection,
    output logic [1:0]      ImmSrc,
    output logic [1:0]      ALUOp,
    output logic [CH_W-1:0] Channel,
    output logic            last,
    output logic            err
);

    localparam logic [1:0]      ST_IDLE   = 2'd0;
    localparam logic [1:0]      ST_HOLD   = 2'd1;
    localparam logic [1:0]      ST_BURST  = 2'd2;
    localparam logic [CH_W-1:0] C_LAST_CH = CH_W'(CHANNELS);
    localparam logic [CH_W-1:0] C_ONE_CH  = CH_W'(1);

    logic [1:0]      state_q, state_d;
    logic            regwrite_q, regwrite_d;
    logic            alusrc_q, alusrc_d;
    logic            memwrite_q, memwrite_d;
    logic            resultsrc_q, resultsrc_d;
    logic            branch_q, branch_d;
    logic            jump_q, jump_d;
    logic            pcdir_q, pcdir_d;
    logic [1:0]      immsrc_q, immsrc_d;
    logic [1:0]      aluop_q, aluop_d;
    logic [CH_W-1:0] chan_q, chan_d;
    logic            last_q, last_d;
    logic            err_q, err_d;

    logic            w_regwrite;
    logic            w_alusrc;
    logic            w_memwrite;
    logic            w_resultsrc;
    logic            w_branch;
    logic            w_jump;
    logic            w_pcdir;
    logic [1:0]      w_immsrc;
    logic [1:0]      w_aluop;
    logic            w_mem;
    logic            w_vector;
    logic            w_illegal;
    logic            w_accept;
    logic            w_out_valid;

    // Instruction field decode
    always_comb begin
        w_regwrite  = 1'b0;
        w_alusrc    = 1'b0;
        w_memwrite  = 1'b0;
        w_resultsrc = 1'b0;
        w_branch    = 1'b0;
        w_jump      = 1'b0;
        w_pcdir     = 1'b0;
        w_immsrc    = 2'b00;
        w_aluop     = 2'b00;
        w_mem       = 1'b0;
        case (tipo)
            2'b00: begin
                w_regwrite = 1'b1;
                w_alusrc   = Inm;
                w_aluop    = 2'b10;
            end
            2'b01: begin
                w_regwrite = 1'b1;
                w_alusrc   = Inm;
                if (op != 2'b00) begin
                    w_resultsrc = 1'b1;
                    w_mem       = 1'b1;
                end
            end
            2'b10: begin
                case (op)
                    2'b00: begin
                        w_jump   = 1'b1;
                        w_immsrc = 2'b10;
                        w_pcdir  = Inm;
                    end
                    2'b01: begin
                        w_jump     = 1'b1;
                        w_immsrc   = 2'b10;
                        w_regwrite = 1'b1;
                    end
                    2'b10:   w_aluop  = 2'b01;
                    default: w_branch = 1'b1;
                endcase
            end
            default: begin
                w_alusrc = Inm;
                if (op == 2'b00) begin
                    w_jump   = 1'b1;
                    w_immsrc = 2'b10;
                end else begin
                    w_memwrite = 1'b1;
                    w_mem      = 1'b1;
                end
            end
        endcase
    end

    assign w_vector  = w_mem && vec;
    // A scalar access naming a channel beyond CHANNELS is suppressed and flagged.
    assign w_illegal = w_mem && !vec && (32'(op) > 32'(CHANNELS));
    assign w_accept  = in_ready && in_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            regwrite_q  <= 1'b0;
            alusrc_q    <= 1'b0;
            memwrite_q  <= 1'b0;
            resultsrc_q <= 1'b0;
            branch_q    <= 1'b0;
            jump_q      <= 1'b0;
            pcdir_q     <= 1'b0;
            immsrc_q    <= 2'b00;
            aluop_q     <= 2'b00;
            chan_q      <= '0;
            last_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            regwrite_q  <= regwrite_d;
            alusrc_q    <= alusrc_d;
            memwrite_q  <= memwrite_d;
            resultsrc_q <= resultsrc_d;
            branch_q    <= branch_d;
            jump_q      <= jump_d;
            pcdir_q     <= pcdir_d;
            immsrc_q    <= immsrc_d;
            aluop_q     <= aluop_d;
            chan_q      <= chan_d;
            last_q      <= last_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        regwrite_d  = regwrite_q;
        alusrc_d    = alusrc_q;
        memwrite_d  = memwrite_q;
        resultsrc_d = resultsrc_q;
        branch_d    = branch_q;
        jump_d      = jump_q;
        pcdir_d     = pcdir_q;
        immsrc_d    = immsrc_q;
        aluop_d     = aluop_q;
        chan_d      = chan_q;
        last_d      = last_q;
        err_d       = err_q;

        if (flush || (!w_accept && out_ready &&
                      ((state_q == ST_HOLD) || (state_q == ST_BURST && last_q)))) begin
            state_d     = ST_IDLE;
            regwrite_d  = 1'b0;
            alusrc_d    = 1'b0;
            memwrite_d  = 1'b0;
            resultsrc_d = 1'b0;
            branch_d    = 1'b0;
            jump_d      = 1'b0;
            pcdir_d     = 1'b0;
            immsrc_d    = 2'b00;
            aluop_d     = 2'b00;
            chan_d      = '0;
            last_d      = 1'b0;
            err_d       = 1'b0;
        end else if (w_accept) begin
            regwrite_d  = w_regwrite && !w_illegal;
            alusrc_d    = w_alusrc;
            memwrite_d  = w_memwrite && !w_illegal;
            resultsrc_d = w_resultsrc;
            branch_d    = w_branch;
            jump_d      = w_jump;
            pcdir_d     = w_pcdir;
            immsrc_d    = w_immsrc;
            aluop_d     = w_aluop;
            if (w_vector) begin
                state_d = ST_BURST;
                chan_d  = C_ONE_CH;
                last_d  = (C_LAST_CH == C_ONE_CH);
                err_d   = 1'b0;
            end else begin
                state_d = ST_HOLD;
                chan_d  = (w_mem && !w_illegal) ? CH_W'(op) : '0;
                last_d  = 1'b1;
                err_d   = w_illegal;
            end
        end else if (state_q == ST_BURST && out_ready) begin
            // Mid-burst advance; the final beat is retired by the branch above.
            chan_d = chan_q + C_ONE_CH;
            last_d = ((chan_q + C_ONE_CH) == C_LAST_CH);
        end
    end

    always_comb begin
        w_out_valid = (state_q != ST_IDLE);
        out_valid   = w_out_valid;
        in_ready    = !rst && !flush &&
                      ((state_q == ST_IDLE) ||
                       (state_q == ST_HOLD && out_ready) ||
                       (state_q == ST_BURST && last_q && out_ready));
        RegWrite    = w_out_valid && regwrite_q;
        ALUSrc      = w_out_valid && alusrc_q;
        MemWrite    = w_out_valid && memwrite_q;
        ResultSrc   = w_out_valid && resultsrc_q;
        Branch      = w_out_valid && branch_q;
        Jump        = w_out_valid && jump_q;
        PCDirection = w_out_valid && pcdir_q;
        ImmSrc      = w_out_valid ? immsrc_q : 2'b00;
        ALUOp       = w_out_valid ? aluop_q : 2'b00;
        Channel     = w_out_valid ? chan_q : '0;
        last        = w_out_valid && last_q;
        err         = w_out_valid && err_q;
    end

endmodule
`default_nettype wire
